// File: rtl/ramp_check_pkg.sv
// Shared types and constants for the ramp pattern checker.
// The pixel slice picks the ramp bits the generator drives onto its colour outputs.
package ramp_check_pkg;

  localparam int CNT_W_DEF = 12;
  localparam int ERR_W_DEF = 16;

  localparam int PIX_MSB = 10;
  localparam int PIX_LSB = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_CHECK   = 2'd2
  } state_e;

endpackage

// File: rtl/ramp_pattern_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ramp_pattern_checker.sv
// Receive-side checker for the horizontal grey ramp test pattern: measures line/frame
// geometry, locks after one measured frame, then checks pixels and timing.
module ramp_pattern_checker
  import ramp_check_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int ERR_W = ERR_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             active_pixel,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic [7:0]       r_in,
  input  logic [7:0]       g_in,
  input  logic [7:0]       b_in,
  input  logic             clear_stats,
  output logic             locked,
  output logic [CNT_W-1:0] line_period,
  output logic [CNT_W-1:0] frame_lines,
  output logic             pixel_err,
  output logic             timing_err,
  output logic [ERR_W-1:0] pixel_err_count,
  output logic [ERR_W-1:0] timing_err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

  state_e state;

  logic                   hs_q;
  logic                   vs_q;
  logic                   hs_rise;
  logic                   vs_rise;
  logic [CNT_W-1:0]       pix_cnt;
  logic [CNT_W-1:0]       line_cnt;
  logic [CNT_W-1:0]       line_cnt_inc;
  logic [CNT_W-1:0]       new_frame_lines;
  logic [CNT_W-1:0]       m;
  logic [PIX_MSB:PIX_LSB] m_d;
  logic [CNT_W-1:0]       ref_period;
  logic [CNT_W-1:0]       ref_lines;
  logic                   line_bad;
  logic                   frame_bad;
  logic                   timing_evt;
  logic                   pixel_evt;

  // Only the expected-pixel slice of the delayed ramp is ever compared, so only it is kept.
  always_comb begin
    hs_rise         = hsync_in & ~hs_q;
    vs_rise         = vsync_in & ~vs_q;
    line_cnt_inc    = (line_cnt == CNT_MAX) ? line_cnt : line_cnt + CNT_ONE;
    new_frame_lines = hs_rise ? line_cnt_inc : line_cnt;
    line_bad        = hs_rise && (line_cnt >= CNT_TWO) && (pix_cnt != ref_period);
    frame_bad       = vs_rise && (new_frame_lines != ref_lines);
    timing_evt      = (state == ST_CHECK) && (line_bad || frame_bad);
    pixel_evt       = (state == ST_CHECK) && active_pixel &&
                      ((r_in != m_d) || (g_in != m_d) || (b_in != m_d));
  end

  assign locked = (state == ST_CHECK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q <= 1'b0;
      vs_q <= 1'b0;
    end else begin
      hs_q <= hsync_in;
      vs_q <= vsync_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_cnt     <= '0;
      line_period <= '0;
    end else if (hs_rise) begin
      pix_cnt     <= CNT_ONE;
      line_period <= pix_cnt;
    end else if (pix_cnt != CNT_MAX) begin
      pix_cnt <= pix_cnt + CNT_ONE;
    end
  end

  // A coincident hsync edge is credited to the frame that is ending and also opens the new one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_cnt    <= '0;
      frame_lines <= '0;
    end else if (vs_rise) begin
      frame_lines <= new_frame_lines;
      line_cnt    <= hs_rise ? CNT_ONE : '0;
    end else if (hs_rise) begin
      line_cnt <= line_cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m   <= '0;
      m_d <= '0;
    end else begin
      m   <= hsync_in ? '0 : m + CNT_ONE;
      m_d <= m[PIX_MSB:PIX_LSB];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      ref_period <= '0;
      ref_lines  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (vs_rise) state <= ST_MEASURE;
        end
        ST_MEASURE: begin
          if (vs_rise) begin
            ref_period <= line_period;
            ref_lines  <= new_frame_lines;
            state      <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (line_bad || frame_bad) state <= ST_MEASURE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_err  <= 1'b0;
      timing_err <= 1'b0;
    end else begin
      pixel_err  <= pixel_evt;
      timing_err <= timing_evt;
    end
  end

  sat_counter #(.W(ERR_W)) u_pixel_err_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear_stats),
    .inc     (pixel_evt),
    .count   (pixel_err_count)
  );

  sat_counter #(.W(ERR_W)) u_timing_err_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear_stats),
    .inc     (timing_evt),
    .count   (timing_err_count)
  );

endmodule

// File: tb/tb_ramp_pattern_checker.sv
// Directed bench for ramp_pattern_checker: drives a reference ramp generator stream and
// checks lock, geometry, pixel/timing errors, counter saturation/clear and async reset.
module tb_ramp_pattern_checker;

  localparam int CNT_W = 12;
  // Narrow error counters so saturation is reachable within a single frame.
  localparam int ERR_W = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             active_pixel;
  logic             hsync_in;
  logic             vsync_in;
  logic [7:0]       r_in;
  logic [7:0]       g_in;
  logic [7:0]       b_in;
  logic             clear_stats;
  logic             locked;
  logic [CNT_W-1:0] line_period;
  logic [CNT_W-1:0] frame_lines;
  logic             pixel_err;
  logic             timing_err;
  logic [ERR_W-1:0] pixel_err_count;
  logic [ERR_W-1:0] timing_err_count;

  int               checks = 0;
  int               errors = 0;
  int               pos;
  int               line_len;
  logic [CNT_W-1:0] gm;
  logic [CNT_W-1:0] gm_d;
  bit               saw_pix;
  bit               saw_tim;

  always #5 clk = ~clk;

  ramp_pattern_checker #(.CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .active_pixel     (active_pixel),
    .hsync_in         (hsync_in),
    .vsync_in         (vsync_in),
    .r_in             (r_in),
    .g_in             (g_in),
    .b_in             (b_in),
    .clear_stats      (clear_stats),
    .locked           (locked),
    .line_period      (line_period),
    .frame_lines      (frame_lines),
    .pixel_err        (pixel_err),
    .timing_err       (timing_err),
    .pixel_err_count  (pixel_err_count),
    .timing_err_count (timing_err_count)
  );

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One pixel clock of the generator: 6-line frames, hsync high 10, vsync rises 5 cycles into line 0.
  task automatic apply_stimulus(input bit corrupt, input bit clr);
    int         line;
    int         c;
    logic [7:0] pix;
    line         = pos / line_len;
    c            = pos % line_len;
    hsync_in     = (c < 10);
    vsync_in     = (pos >= 5) && (pos < 5 + line_len);
    active_pixel = (c >= 10) && (line != 0);
    pix          = gm_d[10:3];
    r_in         = pix;
    g_in         = (corrupt && active_pixel) ? 8'h55 : pix;
    b_in         = pix;
    clear_stats  = clr;
    @(posedge clk);
    #1;
    gm_d = gm;
    gm   = hsync_in ? '0 : gm + 1'b1;
    pos  = (pos + 1) % (6 * line_len);
    if (pixel_err)  saw_pix = 1'b1;
    if (timing_err) saw_tim = 1'b1;
  endtask

  task automatic run_cycles(input int n, input bit corrupt);
    repeat (n) apply_stimulus(corrupt, 1'b0);
  endtask

  task automatic run_to_frame_start();
    while (pos != 0) apply_stimulus(1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_locked"},     locked,           0);
    check_output({tag, "_line_period"}, line_period,     0);
    check_output({tag, "_frame_lines"}, frame_lines,     0);
    check_output({tag, "_pixel_err"},  pixel_err,        0);
    check_output({tag, "_timing_err"}, timing_err,       0);
    check_output({tag, "_pix_count"},  pixel_err_count,  0);
    check_output({tag, "_tim_count"},  timing_err_count, 0);
  endtask

  task automatic restart_generator();
    pos  = 0;
    gm   = '0;
    gm_d = '0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n      = 1'b0;
    active_pixel = 1'b0;
    hsync_in     = 1'b0;
    vsync_in     = 1'b0;
    r_in         = 8'h00;
    g_in         = 8'h00;
    b_in         = 8'h00;
    clear_stats  = 1'b0;
    line_len     = 100;
    saw_pix      = 1'b0;
    saw_tim      = 1'b0;
    restart_generator();

    #12;
    check_all_zero("reset");
    #10 reset_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] clean lock");
    run_cycles(600 + 5, 1'b0);
    check_output("lock_before_2nd_vs", locked, 0);
    run_cycles(1, 1'b0);
    check_output("lock_after_2nd_vs", locked, 1);
    check_output("line_period_100", line_period, 100);
    check_output("frame_lines_6", frame_lines, 6);
    saw_pix = 1'b0;
    saw_tim = 1'b0;
    run_cycles(6000, 1'b0);
    check_output("clean_locked", locked, 1);
    check_output("clean_pix_count", pixel_err_count, 0);
    check_output("clean_tim_count", timing_err_count, 0);
    check_output("clean_no_pix_pulse", saw_pix, 0);
    check_output("clean_no_tim_pulse", saw_tim, 0);

    $display("[TB] single pixel corruption");
    while (pos != 2 * 100 + 50) apply_stimulus(1'b0, 1'b0);
    check_output("pix_err_before", pixel_err, 0);
    apply_stimulus(1'b1, 1'b0);
    check_output("pix_err_pulse", pixel_err, 1);
    check_output("pix_count_1", pixel_err_count, 1);
    apply_stimulus(1'b0, 1'b0);
    check_output("pix_err_single", pixel_err, 0);
    check_output("pix_count_still_1", pixel_err_count, 1);

    $display("[TB] line length change");
    run_to_frame_start();
    line_len = 101;
    run_cycles(303, 1'b0);
    check_output("tim_err_before", timing_err, 0);
    check_output("locked_before_err", locked, 1);
    apply_stimulus(1'b0, 1'b0);
    check_output("tim_err_pulse", timing_err, 1);
    check_output("tim_count_1", timing_err_count, 1);
    check_output("locked_dropped", locked, 0);
    apply_stimulus(1'b0, 1'b0);
    check_output("tim_err_single", timing_err, 0);
    run_to_frame_start();
    run_cycles(5, 1'b0);
    check_output("relock_before_vs", locked, 0);
    run_cycles(1, 1'b0);
    check_output("relocked", locked, 1);
    check_output("line_period_101", line_period, 101);
    check_output("frame_lines_still_6", frame_lines, 6);
    run_cycles(606, 1'b0);
    check_output("relock_stable", locked, 1);
    check_output("tim_count_stays_1", timing_err_count, 1);
    check_output("pix_count_stays_1", pixel_err_count, 1);

    $display("[TB] saturation and clear");
    run_to_frame_start();
    run_cycles(606, 1'b1);
    check_output("pix_count_sat", pixel_err_count, 8'hFF);
    while (pos != 150) apply_stimulus(1'b1, 1'b0);
    check_output("pix_count_holds", pixel_err_count, 8'hFF);
    apply_stimulus(1'b1, 1'b1);
    check_output("clear_beats_inc", pixel_err_count, 0);
    check_output("clear_tim_count", timing_err_count, 0);
    check_output("clear_keeps_lock", locked, 1);
    apply_stimulus(1'b0, 1'b0);
    check_output("pix_count_after_clear", pixel_err_count, 0);

    $display("[TB] async reset mid-frame");
    while (pos != 240) apply_stimulus(1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0);
    check_output("pre_reset_pix_count", pixel_err_count, 1);
    #3 reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
    restart_generator();
    run_cycles(606 + 5, 1'b0);
    check_output("post_reset_before_2nd_vs", locked, 0);
    run_cycles(1, 1'b0);
    check_output("post_reset_relocked", locked, 1);
    check_output("post_reset_line_period", line_period, 101);
    check_output("post_reset_frame_lines", frame_lines, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
